// File: rtl/mips_multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle MIPS controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_ctrl_if;
    logic [5:0] opc;
    logic [5:0] func;
    logic       zero;
    logic       memAck;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluFunc;
    logic       bitXtend;
    logic       rfWriteEnable;
    logic       rfWriteAddrSel;
    logic [1:0] rfWriteDataSel;
    logic       invOpcode;
    logic       memFault;
    logic       busy;

    modport master (
        input  opc, func, zero, memAck,
        output memRead, memWrite, iOrD, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
               aluFunc, bitXtend, rfWriteEnable, rfWriteAddrSel, rfWriteDataSel,
               invOpcode, memFault, busy
    );

    modport slave (
        output opc, func, zero, memAck,
        input  memRead, memWrite, iOrD, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
               aluFunc, bitXtend, rfWriteEnable, rfWriteAddrSel, rfWriteDataSel,
               invOpcode, memFault, busy
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS32 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing over one memory port.
// Optional MC_RETIRE_COUNT_EN adds a 32-bit retired-instruction counter output.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef MC_RETIRE_COUNT_EN
    output logic [31:0] retireCount,
`endif
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI  = 6'h08, OP_ORI = 6'h0D, OP_LW  = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                           FN_SLT = 6'h2A;
    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                           ALU_SUB = 3'b110, ALU_SLT = 3'b111;
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MADDR, S_MRD, S_MWR,
        S_WB_R, S_WB_I, S_WB_M, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic             inv_opcode_q, inv_opcode_d;
    logic             mem_fault_q, mem_fault_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic       func_ok, mem_wait, to_hit;
    logic [2:0] r_alu;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, alu_src_a, bit_xtend;
    logic       rf_we, rf_wa_sel, busy;
    logic [1:0] pc_src, alu_src_b, rf_wd_sel;
    logic [2:0] alu_func;

    always_comb begin
        func_ok = 1'b1;
        r_alu   = ALU_ADD;
        case (bus.func)
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_SLT:  r_alu = ALU_SLT;
            default: func_ok = 1'b0;
        endcase
    end

    // An ack on the limit cycle wins: to_hit only fires while memAck is low.
    assign mem_wait = (state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR);
    assign to_hit   = (MEM_TIMEOUT > 0) && !bus.memAck && ((wait_cnt_q + CNT_W'(1)) == TO_LIM);

    always_comb begin
        state_d      = state_q;
        inv_opcode_d = inv_opcode_q;
        mem_fault_d  = mem_fault_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_func     = 3'b000;
        bit_xtend    = 1'b0;
        rf_we        = 1'b0;
        rf_wa_sel    = 1'b0;
        rf_wd_sel    = 2'b00;
        busy         = 1'b1;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_func  = ALU_ADD;
                if (bus.memAck) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (to_hit) begin
                    mem_fault_d = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_func  = ALU_ADD;
                case (bus.opc)
                    OP_RTYPE: begin
                        if (func_ok) state_d = S_EXEC_R;
                        else begin
                            inv_opcode_d = 1'b1;
                            state_d      = S_TRAP;
                        end
                    end
                    OP_LW, OP_SW:    state_d = S_MADDR;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_ORI: state_d = S_EXEC_I;
                    default: begin
                        inv_opcode_d = 1'b1;
                        state_d      = S_TRAP;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_func  = r_alu;
                state_d   = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_func  = (bus.opc == OP_ORI) ? ALU_OR : ALU_ADD;
                bit_xtend = (bus.opc == OP_ORI);
                state_d   = S_WB_I;
            end
            S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_func  = ALU_ADD;
                state_d   = (bus.opc == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (bus.memAck) state_d = S_WB_M;
                else if (to_hit) begin
                    mem_fault_d = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_MWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (bus.memAck) state_d = S_FETCH;
                else if (to_hit) begin
                    mem_fault_d = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_WB_R: begin
                rf_we     = 1'b1;
                rf_wa_sel = 1'b1;
                state_d   = S_FETCH;
            end
            S_WB_I: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_M: begin
                rf_we     = 1'b1;
                rf_wd_sel = 2'b01;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_func  = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = ((bus.opc == OP_BEQ) && bus.zero) || ((bus.opc == OP_BNE) && !bus.zero);
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = S_FETCH;
            end
            S_TRAP:  busy = 1'b0;
            default: state_d = S_FETCH;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)          wait_cnt_d = '0;
        else if (mem_wait && !bus.memAck) wait_cnt_d = wait_cnt_q + CNT_W'(1);

        // Reset may land mid-access; quiet every output so no strobe leaks that cycle.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            i_or_d    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'b00;
            alu_src_a = 1'b0;
            alu_src_b = 2'b00;
            alu_func  = 3'b000;
            bit_xtend = 1'b0;
            rf_we     = 1'b0;
            rf_wa_sel = 1'b0;
            rf_wd_sel = 2'b00;
            busy      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            inv_opcode_q <= 1'b0;
            mem_fault_q  <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            inv_opcode_q <= inv_opcode_d;
            mem_fault_q  <= mem_fault_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

`ifdef MC_RETIRE_COUNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        retire;

    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_WB_R, S_WB_I, S_WB_M, S_MWR, S_BRANCH, S_JUMP});

    always_comb retire_cnt_d = retire_cnt_q + 32'(retire);

    always_ff @(posedge clk) begin
        if (rst) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retireCount = retire_cnt_q;
`endif

    assign bus.memRead        = mem_read;
    assign bus.memWrite       = mem_write;
    assign bus.iOrD           = i_or_d;
    assign bus.irWrite        = ir_write;
    assign bus.pcWrite        = pc_write;
    assign bus.pcSrc          = pc_src;
    assign bus.aluSrcA        = alu_src_a;
    assign bus.aluSrcB        = alu_src_b;
    assign bus.aluFunc        = alu_func;
    assign bus.bitXtend       = bit_xtend;
    assign bus.rfWriteEnable  = rf_we;
    assign bus.rfWriteAddrSel = rf_wa_sel;
    assign bus.rfWriteDataSel = rf_wd_sel;
    assign bus.invOpcode      = inv_opcode_q;
    assign bus.memFault       = mem_fault_q;
    assign bus.busy           = busy;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl (MEM_TIMEOUT=4); compares the packed output
// word each cycle against hand-derived per-state expectations.
module tb_mips_multicycle_ctrl;
    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                           A_SUB = 3'b110, A_SLT = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [20:0] exp_v;
    logic [5:0]  fn_tab [4];
    logic [2:0]  af_tab [4];
    logic [5:0]  br_opc [4];
    logic        br_zero[4];
    logic        br_pcw [4];

    mips_multicycle_ctrl_if bus();
`ifdef MC_RETIRE_COUNT_EN
    logic [31:0] retire_count;
`endif

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef MC_RETIRE_COUNT_EN
        .retireCount(retire_count),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [20:0] outs();
        return {bus.memRead, bus.memWrite, bus.iOrD, bus.irWrite, bus.pcWrite, bus.pcSrc,
                bus.aluSrcA, bus.aluSrcB, bus.aluFunc, bus.bitXtend, bus.rfWriteEnable,
                bus.rfWriteAddrSel, bus.rfWriteDataSel, bus.invOpcode, bus.memFault, bus.busy};
    endfunction

    function automatic logic [20:0] ctl(input logic mr, mw, iod, irw, pcw, input logic [1:0] pcs,
                                        input logic asa, input logic [1:0] asb, input logic [2:0] af,
                                        input logic bx, rfwe, rfwa, input logic [1:0] rfwd,
                                        input logic inv, flt, bsy);
        return {mr, mw, iod, irw, pcw, pcs, asa, asb, af, bx, rfwe, rfwa, rfwd, inv, flt, bsy};
    endfunction

    function automatic logic [20:0] e_fetch(input logic ack);
        return ctl(1, 0, 0, ack, ack, 2'b00, 0, 2'b01, A_ADD, 0, 0, 0, 2'b00, 0, 0, 1);
    endfunction

    function automatic logic [20:0] e_decode();
        return ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, A_ADD, 0, 0, 0, 2'b00, 0, 0, 1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.memAck = 1'b0;
        repeat (2) cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL reset_hold: got %h want %h", outs(), exp_v); end
        rst = 1'b0;
        #1;
        exp_v = e_fetch(0);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL reset_fetch: got %h want %h", outs(), exp_v); end
    endtask

    task automatic test_rtype();
        bus.opc = 6'h00; bus.func = 6'h24; bus.memAck = 1'b1;
        #1;
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL and_fetch: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = e_decode();
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL and_decode: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, A_AND, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL and_exec: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL and_wb: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL and_refetch: got %h want %h", outs(), exp_v); end
    endtask

    task automatic test_rtype_funcs();
        fn_tab = '{6'h20, 6'h22, 6'h25, 6'h2A};
        af_tab = '{A_ADD, A_SUB, A_OR, A_SLT};
        bus.memAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.opc = 6'h00; bus.func = fn_tab[i];
            cyc(); cyc();
            exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, af_tab[i], 0, 0, 0, 2'b00, 0, 0, 1);
            checks++; if (outs() !== exp_v) begin errors++; $display("FAIL rfunc_exec[%0d]: got %h want %h", i, outs(), exp_v); end
            cyc(); cyc();
        end
    endtask

    task automatic test_itype();
        bus.memAck = 1'b1;
        bus.opc = 6'h08;
        cyc(); cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, A_ADD, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL addi_exec: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL addi_wb: got %h want %h", outs(), exp_v); end
        cyc();
        bus.opc = 6'h0D;
        cyc(); cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, A_OR, 1, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL ori_exec: got %h want %h", outs(), exp_v); end
        cyc(); cyc();
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL ori_refetch: got %h want %h", outs(), exp_v); end
    endtask

    task automatic test_lw_delay();
        bus.opc = 6'h23; bus.memAck = 1'b1;
        cyc(); cyc();
        bus.memAck = 1'b0;
        #1;
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, A_ADD, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL lw_maddr: got %h want %h", outs(), exp_v); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) bus.memAck = 1'b1;
            #1;
            exp_v = ctl(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1);
            checks++; if (outs() !== exp_v) begin errors++; $display("FAIL lw_mrd[%0d]: got %h want %h", i, outs(), exp_v); end
        end
        cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0, 2'b01, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL lw_wbm: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL lw_refetch: got %h want %h", outs(), exp_v); end
    endtask

    task automatic test_sw();
        bus.opc = 6'h2B; bus.memAck = 1'b1;
        cyc(); cyc(); cyc();
        exp_v = ctl(0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL sw_mwr: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL sw_refetch: got %h want %h", outs(), exp_v); end
    endtask

    task automatic test_branch();
        br_opc  = '{6'h05, 6'h05, 6'h04, 6'h04};
        br_zero = '{1'b0, 1'b1, 1'b1, 1'b0};
        br_pcw  = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.memAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.opc = br_opc[i]; bus.zero = br_zero[i];
            cyc(); cyc();
            exp_v = ctl(0, 0, 0, 0, br_pcw[i], 2'b01, 1, 2'b00, A_SUB, 0, 0, 0, 2'b00, 0, 0, 1);
            checks++; if (outs() !== exp_v) begin errors++; $display("FAIL branch[%0d]: got %h want %h", i, outs(), exp_v); end
            cyc();
        end
        bus.zero = 1'b0;
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL branch_refetch: got %h want %h", outs(), exp_v); end
    endtask

    task automatic test_jump();
        bus.opc = 6'h02; bus.memAck = 1'b1;
        cyc(); cyc();
        exp_v = ctl(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL jump: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL jump_refetch: got %h want %h", outs(), exp_v); end
    endtask

    task automatic test_trap();
        bus.opc = 6'h3F; bus.memAck = 1'b1;
        cyc();
        exp_v = e_decode();
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL trap_decode: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 1, 0, 0);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL trap_entry: got %h want %h", outs(), exp_v); end
        for (int i = 0; i < 20; i++) begin
            bus.memAck = i[0];
            cyc();
            checks++; if (outs() !== exp_v) begin errors++; $display("FAIL trap_hold[%0d]: got %h want %h", i, outs(), exp_v); end
        end
        rst = 1'b1; bus.memAck = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL trap_reset: got %h want %h", outs(), exp_v); end
        bus.opc = 6'h00; bus.func = 6'h3F;
        cyc(); cyc();
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 1, 0, 0);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL badfunc_trap: got %h want %h", outs(), exp_v); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_timeout();
        bus.memAck = 1'b0; bus.opc = 6'h02;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_v = e_fetch(0);
            checks++; if (outs() !== exp_v) begin errors++; $display("FAIL to_wait[%0d]: got %h want %h", i, outs(), exp_v); end
            cyc();
        end
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 1, 0);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL to_trap: got %h want %h", outs(), exp_v); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_v = e_fetch(0);
            checks++; if (outs() !== exp_v) begin errors++; $display("FAIL to_late_wait[%0d]: got %h want %h", i, outs(), exp_v); end
            cyc();
        end
        bus.memAck = 1'b1;
        #1;
        exp_v = e_fetch(1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL to_late_ack: got %h want %h", outs(), exp_v); end
        cyc();
        exp_v = e_decode();
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL to_no_fault: got %h want %h", outs(), exp_v); end
        cyc(); cyc();
    endtask

    task automatic test_reset_mwr();
        bus.opc = 6'h2B; bus.memAck = 1'b1;
        cyc(); cyc();
        bus.memAck = 1'b0;
        cyc();
        exp_v = ctl(0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL mwr_wait: got %h want %h", outs(), exp_v); end
        rst = 1'b1;
        #1;
        exp_v = ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL mwr_rst: got %h want %h", outs(), exp_v); end
        cyc();
        rst = 1'b0;
        #1;
        exp_v = e_fetch(0);
        checks++; if (outs() !== exp_v) begin errors++; $display("FAIL mwr_rst_fetch: got %h want %h", outs(), exp_v); end
    endtask

`ifdef MC_RETIRE_COUNT_EN
    task automatic test_retire();
        checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL retire_zero: got %0d want 0", retire_count); end
        bus.memAck = 1'b1; bus.zero = 1'b0;
        bus.opc = 6'h00; bus.func = 6'h24;
        repeat (4) cyc();
        bus.opc = 6'h2B;
        repeat (4) cyc();
        bus.opc = 6'h04;
        repeat (3) cyc();
        checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL retire_three: got %0d want 3", retire_count); end
        bus.opc = 6'h3F;
        repeat (4) cyc();
        checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL retire_trap: got %0d want 3", retire_count); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask
`endif

    initial begin
        bus.opc = 6'h00; bus.func = 6'h00; bus.zero = 1'b0; bus.memAck = 1'b0;
        test_reset();
        test_rtype();
        test_rtype_funcs();
        test_itype();
        test_lw_delay();
        test_sw();
        test_branch();
        test_jump();
        test_trap();
        test_timeout();
        test_reset_mwr();
`ifdef MC_RETIRE_COUNT_EN
        test_retire();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
